// File: rtl/conway_pixel_fetch.sv
// Streams one frame of Game-of-Life cells from grid memory port B as a pixel stream.
// Reads are throttled so shifter + FIFO + in-flight reads never exceed three words.
module conway_pixel_fetch #(
    parameter int unsigned WORDS_PER_ROW = 64,
    parameter int unsigned ROWS          = 1024,
    parameter int unsigned WORD_BITS     = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [15:0]          address_b,
    input  logic [WORD_BITS-1:0] q_b,
    input  logic                 wait_request,
    output logic                 pix,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_last_in_row,
    output logic                 pix_last_in_frame,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned COLS = WORDS_PER_ROW * WORD_BITS;
    localparam int unsigned IW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [IW-1:0] BIT_LAST  = IW'(WORD_BITS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [15:0]   ADDR_LAST = 16'(WORDS_PER_ROW * ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [15:0]          addr;
    logic                 rd_pend;
    logic [WORD_BITS-1:0] fifo_mem [2];
    logic                 fifo_rp;
    logic                 fifo_wp;
    logic [1:0]           fifo_cnt;
    logic [WORD_BITS-1:0] shifter;
    logic                 sh_full;
    logic [IW-1:0]        bit_idx;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;

    logic       hs;
    logic       at_row_end;
    logic       at_frame_end;
    logic       sh_free;
    logic       load_fifo;
    logic       load_q;
    logic       push;
    logic       issue;
    logic       clear;
    logic [2:0] occupancy;

    always_comb begin
        occupancy    = 3'(sh_full) + 3'(fifo_cnt) + 3'(rd_pend);
        hs           = sh_full && pix_ready;
        at_row_end   = (col == COL_LAST);
        at_frame_end = at_row_end && (row == ROW_LAST);
        // Shifter counts as free when it is empty or its last bit is leaving this cycle.
        sh_free      = !sh_full || (hs && (bit_idx == BIT_LAST));
        load_fifo    = sh_free && (fifo_cnt != 2'd0);
        load_q       = sh_free && (fifo_cnt == 2'd0) && rd_pend;
        push         = rd_pend && !load_q;
        issue        = (state == RUN) && (occupancy < 3'd3) && !wait_request;
        clear        = abort || ((state == IDLE) && start);
    end

    assign address_b         = addr;
    assign pix               = sh_full & shifter[bit_idx];
    assign pix_valid         = sh_full;
    assign pix_last_in_row   = sh_full && at_row_end;
    assign pix_last_in_frame = sh_full && at_frame_end;
    assign busy              = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            rd_pend    <= 1'b0;
            fifo_rp    <= 1'b0;
            fifo_wp    <= 1'b0;
            fifo_cnt   <= '0;
            sh_full    <= 1'b0;
            bit_idx    <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                // Abort and start share the flush; abort additionally keeps the block idle.
                state    <= abort ? IDLE : RUN;
                addr     <= '0;
                rd_pend  <= 1'b0;
                fifo_rp  <= 1'b0;
                fifo_wp  <= 1'b0;
                fifo_cnt <= '0;
                sh_full  <= 1'b0;
                bit_idx  <= '0;
                col      <= '0;
                row      <= '0;
            end else begin
                rd_pend <= issue;
                if (issue) begin
                    if (addr == ADDR_LAST) begin
                        state <= DRAIN;
                    end else begin
                        addr <= addr + 16'd1;
                    end
                end
                if (push) begin
                    fifo_wp <= ~fifo_wp;
                end
                if (load_fifo) begin
                    fifo_rp <= ~fifo_rp;
                end
                fifo_cnt <= fifo_cnt + 2'(push) - 2'(load_fifo);
                if (sh_free) begin
                    sh_full <= load_fifo || load_q;
                end
                if (hs) begin
                    bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + IW'(1);
                    if (at_row_end) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                    if ((state == DRAIN) && at_frame_end) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Data storage needs no reset: validity is tracked by sh_full and the FIFO pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wp] <= q_b;
        end
        if (load_fifo) begin
            shifter <= fifo_mem[fifo_rp];
        end else if (load_q) begin
            shifter <= q_b;
        end
    end

endmodule

// File: tb/tb_conway_pixel_fetch.sv
// Bench for conway_pixel_fetch on a reduced grid, driven by a synchronous-read memory model.
module tb_conway_pixel_fetch;

    localparam int WPR   = 4;
    localparam int NR    = 8;
    localparam int WB    = 20;
    localparam int NW    = WPR * NR;
    localparam int COLS  = WPR * WB;
    localparam int TOTAL = NW * WB;
    localparam int LAST  = NW - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   address_b;
    logic [WB-1:0] q_b = '0;
    logic          wait_request = 1'b0;
    logic          pix;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          pix_last_in_row;
    logic          pix_last_in_frame;
    logic          busy;
    logic          frame_done;

    logic [WB-1:0] mem [NW];

    int total_chk = 0;
    int bad_chk   = 0;

    conway_pixel_fetch #(
        .WORDS_PER_ROW(WPR),
        .ROWS(NR),
        .WORD_BITS(WB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .address_b(address_b),
        .q_b(q_b),
        .wait_request(wait_request),
        .pix(pix),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_last_in_row(pix_last_in_row),
        .pix_last_in_frame(pix_last_in_frame),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Grid memory: data for the address presented in one cycle appears in the next.
    always @(posedge clk) q_b <= mem[address_b[4:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_chk++;
        assert (obs === exp) else begin
            bad_chk++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NW; i++) mem[i] = 20'($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"}, 32'(address_b), 32'd0);
        chk({tag, "_pix"}, 32'(pix), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_lrow"}, 32'(pix_last_in_row), 32'd0);
        chk({tag, "_lframe"}, 32'(pix_last_in_frame), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    // Streams one frame and compares every accepted pixel with the memory image.
    task automatic run_frame(input int ready_pct, input int wait_cyc, input int exp_first,
                             input int abort_at, input int busy_start_at, input int reset_at);
        int          k = 0;
        int          cyc = 0;
        int          first = -1;
        int          last_hs = 0;
        bit          hold = 1'b0;
        bit          prev_wait = 1'b0;
        bit          rdy;
        bit          bs_fired = 1'b0;
        logic [3:0]  prev = '0;
        logic [15:0] last_addr = '0;
        logic [4:0]  wi;
        logic [WB-1:0] w;
        logic        exp_bit;

        @(negedge clk);
        start = 1'b1;
        wait_request = (wait_cyc > 0);
        while (k < TOTAL && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                chk("first_addr", 32'(address_b), 32'd0);
                chk("busy_run", 32'(busy), 32'd1);
            end else if (prev_wait) begin
                chk("addr_hold", 32'(address_b), 32'(last_addr));
            end else begin
                chk("addr_step", 32'((address_b == last_addr) || (address_b == last_addr + 16'd1)), 32'd1);
            end
            last_addr = address_b;
            wait_request = (cyc < wait_cyc) || (cyc == wait_cyc);
            prev_wait = wait_request;
            chk("no_done_midframe", 32'(frame_done), 32'd0);
            if (hold)
                chk("hold_stable", 32'({pix, pix_valid, pix_last_in_row, pix_last_in_frame}), 32'(prev));
            if (pix_valid && first < 0) begin
                first = cyc;
                chk("first_valid_cycle", 32'(cyc), 32'(exp_first));
            end
            rdy = (int'($urandom_range(0, 99)) < ready_pct);
            pix_ready = rdy;
            if (pix_valid && rdy) begin
                wi = 5'(k / WB);
                w = mem[wi];
                exp_bit = w[0];
                w = w >> (k % WB);
                exp_bit = w[0];
                chk("pix", 32'(pix), 32'(exp_bit));
                chk("last_in_row", 32'(pix_last_in_row), 32'((k % COLS) == COLS - 1));
                chk("last_in_frame", 32'(pix_last_in_frame), 32'(k == TOTAL - 1));
                k++;
                last_hs = cyc;
            end
            hold = pix_valid && !rdy;
            prev = {pix, pix_valid, pix_last_in_row, pix_last_in_frame};
            if (k == busy_start_at && !bs_fired) begin
                bs_fired = 1'b1;
                start = 1'b1;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                pix_ready = 1'b0;
                wait_request = 1'b0;
                check_idle_outputs("abort");
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_stays_idle", 32'({busy, frame_done, pix_valid}), 32'd0);
                end
                return;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                #1;
                check_idle_outputs("reset_mid");
                @(negedge clk);
                reset = 1'b0;
                pix_ready = 1'b0;
                wait_request = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("reset_stays_idle", 32'({busy, pix_valid, frame_done}), 32'd0);
                end
                return;
            end
        end
        if (k < TOTAL) begin
            chk("timeout_handshakes", 32'(k), 32'(TOTAL));
            pix_ready = 1'b0;
            return;
        end
        @(negedge clk);
        pix_ready = 1'b0;
        wait_request = 1'b0;
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("valid_after_done", 32'(pix_valid), 32'd0);
        chk("last_issued_addr", 32'(address_b), 32'(LAST));
        if (ready_pct == 100)
            chk("throughput", 32'(last_hs - first + 1), 32'(TOTAL));
        @(negedge clk);
        chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    endtask

    initial begin
        fill_mem();
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // First word has only its leftmost pixel alive.
        fill_mem();
        mem[0] = 20'h00001;
        run_frame(100, 0, 3, -1, -1, -1);

        fill_mem();
        run_frame(30, 0, 3, -1, -1, -1);

        fill_mem();
        run_frame(100, 5, 8, -1, -1, -1);

        fill_mem();
        run_frame(50, 0, 3, 300, -1, -1);
        fill_mem();
        run_frame(70, 0, 3, -1, 100, -1);

        fill_mem();
        run_frame(80, 0, 3, -1, 150, 200);
        fill_mem();
        run_frame(100, 0, 3, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
        $finish;
    end

endmodule
